seq_divider_32: RTL and testbench

//   Multi-cycle restoring divider: the inverse of the add/subtract datapath. It

---
 rtl/seq_divider_32_pkg.sv | 18 +
 rtl/seq_divider_32_div_step.sv | 26 ++
 rtl/seq_divider_32.sv | 118 +++++++++++
 tb/tb_seq_divider_32.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_32_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_32_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } div_state_t;

  localparam int ST_V = 3;
  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_C = 0;

endpackage

// File: rtl/seq_divider_32_div_step.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract divisor.
module div_step
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_dvd
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           carry;

  assign rem_sh = {rem, dvd[WIDTH-1]};

  // Subtract as add-of-complement; carry out set means no borrow, i.e. diff >= 0.
  assign {carry, diff} = {1'b0, rem_sh} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};

  assign next_rem = carry ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign next_dvd = {dvd[WIDTH-2:0], carry};

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
// state  | meaning
// IDLE   | waiting for start, result registers hold
// PREP   | take magnitudes, record signs, load counter
// RUN    | one restoring step per clock
// FINISH | sign fix, load Q/R/status, pulse done
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic [3:0]       status,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b, rem, dvd, dsr;
  logic             op_sgn, q_neg, r_neg, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, next_rem, next_dvd, q_res, r_res;
  logic [3:0]       st_res;

  assign a_mag = (op_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag = (op_sgn && op_b[WIDTH-1]) ? -op_b : op_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .divisor  (dsr),
    .next_rem (next_rem),
    .next_dvd (next_dvd)
  );

  // The overflow case needs no special quotient: |MOST_NEG| / 1 already yields MOST_NEG.
  always_comb begin
    q_res  = div_zero ? {WIDTH{1'b1}} : (q_neg ? -dvd : dvd);
    r_res  = div_zero ? op_a : (r_neg ? -rem : rem);
    st_res = 4'b0000;
    st_res[ST_V] = div_zero | ovf;
    st_res[ST_Z] = (q_res == '0);
    st_res[ST_N] = q_res[WIDTH-1];
    st_res[ST_C] = (r_res != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_sgn   <= 1'b0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      Q        <= '0;
      R        <= '0;
      status   <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= A;
            op_b   <= B;
            op_sgn <= sgn;
            busy   <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          dvd      <= a_mag;
          dsr      <= b_mag;
          rem      <= '0;
          cnt      <= CNT_W'(WIDTH);
          q_neg    <= op_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          r_neg    <= op_sgn & op_a[WIDTH-1];
          div_zero <= (op_b == '0);
          ovf      <= op_sgn && (op_a == MOST_NEG) && (op_b == {WIDTH{1'b1}});
          state    <= (op_b == '0) ? FINISH : RUN;
        end
        RUN: begin
          rem <= next_rem;
          dvd <= next_dvd;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FINISH;
        end
        FINISH: begin
          Q      <= q_res;
          R      <= r_res;
          status <= st_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed self-checking bench for seq_divider_32.
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] A, B, Q, R;
  logic [3:0]  status;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  seq_divider_32 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sgn    (sgn),
    .A      (A),
    .B      (B),
    .Q      (Q),
    .R      (R),
    .status (status),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where done is seen (lat = edges after accept).
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    sgn = s; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] eq, input logic [31:0] er,
                              input logic [3:0] es, input int lat, input int elat);
    total++;
    if (Q !== eq) begin bad++; $display("FAIL %s Q got=%h exp=%h", name, Q, eq); end
    total++;
    if (R !== er) begin bad++; $display("FAIL %s R got=%h exp=%h", name, R, er); end
    total++;
    if (status !== es) begin bad++; $display("FAIL %s status got=%b exp=%b", name, status, es); end
    total++;
    if (lat !== elat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%b exp=0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({Q, R, status, busy, done} !== 70'd0) begin
      bad++; $display("FAIL reset_state got Q=%h R=%h st=%b busy=%b done=%b exp all 0", Q, R, status, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(1'b0, 32'd100, 32'd7, lat);
    check_result("u100_7", 32'd14, 32'd2, 4'b0001, lat, 34);
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    run_op(1'b0, 32'd12, 32'd4, lat);
    check_result("u12_4", 32'd3, 32'd0, 4'b0000, lat, 34);
    @(negedge clk);
  endtask

  task automatic test_signed();
    int lat;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    check_result("s-7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0011, lat, 34);
    @(negedge clk);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    check_result("s7_-2", 32'hFFFF_FFFD, 32'd1, 4'b0011, lat, 34);
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat);
    check_result("s-7_-2", 32'd3, 32'hFFFF_FFFF, 4'b0001, lat, 34);
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(1'b0, 32'd5, 32'd0, lat);
    check_result("divzero", 32'hFFFF_FFFF, 32'd5, 4'b1011, lat, 2);
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check_result("ovf", 32'h8000_0000, 32'd0, 4'b1010, lat, 34);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    sgn = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid_run got=%b exp=1", busy); end
    A = 32'd9; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_result("ignored_start", 32'd14, 32'd2, 4'b0001, lat, 34);
    run_op(1'b0, 32'd9, 32'd3, lat);
    check_result("start_in_done", 32'd3, 32'd0, 4'b0000, lat, 34);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    sgn = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({Q, R, status, busy, done} !== 70'd0) begin
      bad++; $display("FAIL reset_mid_run got Q=%h R=%h st=%b busy=%b done=%b exp all 0", Q, R, status, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL no_done_after_reset got=%0d exp=0", seen); end
    run_op(1'b0, 32'd100, 32'd7, lat);
    check_result("after_reset", 32'd14, 32'd2, 4'b0001, lat, 34);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
